// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// Limb width is fixed by the downstream adder32.
package mp_add_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        CAPT
    } state_t;

    // Limb index width; WORDS is always >= 2, the guard only keeps the width legal.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/adder32.sv
// Registered 32-bit adder with carry in/out, one-cycle latency.
// Shares clk and the synchronous active-low rst_n with the sequencer.
module adder32
    import mp_add_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              c_i,
    output logic [WORD_W-1:0] sum_o,
    output logic              cout_o
);

    logic [WORD_W:0] total;

    assign total = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, c_i};

    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_o  <= '0;
            cout_o <= 1'b0;
        end else begin
            sum_o  <= total[WORD_W-1:0];
            cout_o <= total[WORD_W];
        end
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: feeds a registered 32-bit adder one limb at a
// time (LSW first), chains the carry and assembles the wide sum.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WORD_W*WORDS-1:0]   a_wide,
    input  logic [WORD_W*WORDS-1:0]   b_wide,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [WORD_W*WORDS-1:0]   result,
    output logic                      cout,
    output logic                      ovf,
    output logic [WORD_W-1:0]         add_a,
    output logic [WORD_W-1:0]         add_b,
    output logic                      add_c,
    input  logic [WORD_W-1:0]         add_sum,
    input  logic                      add_cout
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      result_q, result_d;
    logic [WORD_W-1:0] add_a_q, add_a_d;
    logic [WORD_W-1:0] add_b_q, add_b_d;
    logic              add_c_q, add_c_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              last_limb;

    assign last_limb = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FEED;
            FEED:    state_d = CAPT;
            CAPT:    state_d = last_limb ? IDLE : FEED;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal assigned here gets a hold/default value first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        add_c_d  = add_c_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_wide;
                    b_d     = b_wide;
                    idx_d   = '0;
                    add_a_d = a_wide[WORD_W-1:0];
                    add_b_d = b_wide[WORD_W-1:0];
                    add_c_d = cin;
                end
            end
            CAPT: begin
                result_d[idx_q*WORD_W +: WORD_W] = add_sum;
                if (!last_limb) begin
                    // Carry for the next limb comes straight from the adder's register.
                    idx_d   = idx_q + IDX_W'(1);
                    add_a_d = a_q[idx_d*WORD_W +: WORD_W];
                    add_b_d = b_q[idx_d*WORD_W +: WORD_W];
                    add_c_d = add_cout;
                end else begin
                    cout_d = add_cout;
                    ovf_d  = (a_q[W-1] == b_q[W-1]) && (add_sum[WORD_W-1] != a_q[W-1]);
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the operand latches are reset along with the control state so a
    // reset leaves no trace of an aborted request anywhere in the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_c_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            add_c_q  <= add_c_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign add_a  = add_a_q;
    assign add_b  = add_b_q;
    assign add_c  = add_c_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq driving a real adder32, WORDS=4.
// Expected sums come from a 129-bit reference add pushed to a scoreboard queue.
module tb_mp_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_wide;
    logic [W-1:0] b_wide;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_c;
    logic [31:0]  add_sum;
    logic         add_cout;

    int   total;
    int   bad;
    int   done_cnt;
    exp_t sb[$];

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_wide   (a_wide),
        .b_wide   (b_wide),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_c    (add_c),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    adder32 u_adder (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_i    (add_a),
        .b_i    (add_b),
        .c_i    (add_c),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        exp_t       e;
        s      = {1'b0, a} + {1'b0, b} + (W + 1)'(c);
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_wide = a;
        b_wide = b;
        cin    = c;
        start  = 1'b1;
        sb.push_back(model(a, b, c));
    endtask

    // Scoreboard side: every done pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("cout", cout, e.cout);
                check("ovf", ovf, e.ovf);
            end
        end
    end

    // mode 0: plain; 1: ignored starts + restart in done cycle;
    // 2: operands churn after start; 3: reset mid-request.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int mode, input logic [3:0] exp_addc, input bit chk_addc);
        int         lat;
        int         d0;
        bit         seen;
        logic [3:0] addc_seen;
        logic [8:0] busy_seen;
        lat       = -1;
        seen      = 1'b0;
        d0        = done_cnt;
        addc_seen = '0;
        busy_seen = '0;
        @(negedge clk);
        issue(a, b, c);
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mode == 2) begin
                a_wide = rnd();
                b_wide = rnd();
                cin    = ~cin;
            end
            if (mode == 1) begin
                start = (n >= 1 && n <= 4);
                if (start) begin
                    a_wide = rnd();
                    b_wide = rnd();
                end
            end
            if (mode == 3 && n == 2) rst_n = 1'b0;
            if (mode == 3 && n == 3) begin
                check("rst_result", result, 0);
                check("rst_cout", cout, 0);
                check("rst_ovf", ovf, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_add_a", add_a, 0);
                check("rst_add_b", add_b, 0);
                check("rst_add_c", add_c, 0);
                rst_n = 1'b1;
            end
            if (n < 8 && n % 2 == 0) addc_seen[n/2] = add_c;
            if (n <= 8) busy_seen[n] = busy;
            if (done && !seen) begin
                seen = 1'b1;
                lat  = n;
                if (mode == 1) issue(rnd(), rnd(), 1'b1);
            end
            if (seen && mode != 3) break;
        end
        if (mode == 3) begin
            check("rst_no_done", done_cnt - d0, 0);
            sb.delete();
        end else begin
            check("latency", lat, 8);
            check("busy_pattern", busy_seen, 9'h0FF);
            if (chk_addc) check("add_c_limbs", addc_seen, exp_addc);
        end
        if (mode == 1) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("busy_after_restart", busy, 1);
            for (int n = 0; n < 30 && done_cnt < d0 + 2; n++) @(negedge clk);
            @(posedge clk);
            check("restart_done_cnt", done_cnt, d0 + 2);
        end
    endtask

    initial begin
        logic [W-1:0] all_ones;
        logic [W-1:0] max_pos;
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        all_ones = {WORDS{32'hFFFF_FFFF}};
        max_pos  = {32'h7FFF_FFFF, {(WORDS-1){32'hFFFF_FFFF}}};
        rst_n    = 1'b0;
        start    = 1'b0;
        a_wide   = '0;
        b_wide   = '0;
        cin      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_cout", cout, 0);
        check("reset_ovf", ovf, 0);
        check("reset_add_a", add_a, 0);
        check("reset_add_b", add_b, 0);
        check("reset_add_c", add_c, 0);
        rst_n = 1'b1;

        run_op(all_ones, 1, 1'b0, 0, 4'b1110, 1'b1);
        run_op(max_pos, 1, 1'b0, 0, 4'b0000, 1'b0);
        run_op('0, '0, 1'b1, 0, 4'b0001, 1'b1);
        run_op(rnd(), rnd(), 1'b0, 0, 4'b0000, 1'b0);
        run_op(rnd(), rnd(), 1'b1, 0, 4'b0000, 1'b0);
        run_op(rnd(), rnd(), 1'b1, 1, 4'b0000, 1'b0);
        run_op(rnd(), rnd(), 1'b0, 3, 4'b0000, 1'b0);
        run_op(5, 7, 1'b0, 0, 4'b0000, 1'b0);
        run_op(rnd(), rnd(), 1'b1, 2, 4'b0000, 1'b0);

        repeat (4) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add sequencer placed directly upstream of the registered 32-bit adder (`adder32`, one-cycle latency). It latches two WORDS×32-bit operands and a carry-in, then feeds the adder one 32-bit limb at a time, LSW first. Each limb's carry-out is chained back as the next limb's carry-in. The sequencer collects the sums into a wide result and reports final carry, signed overflow and completion to the requester.

## Interface
Parameters:
- WORDS, 4, number of 32-bit limbs (≥2); operand width is 32·WORDS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low; the sequencer and adder share it.
- start  in  1  request; sampled only in IDLE.
- a_wide  in  32·WORDS  operand A, latched on an accepted start.
- b_wide  in  32·WORDS  operand B, latched on an accepted start.
- cin  in  1  initial carry, latched on an accepted start.
- busy  out  1  high while a request is in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse when the result is valid.
- result  out  32·WORDS  wide sum; held until the next accepted start.
- cout  out  1  carry out of the MS limb.
- ovf  out  1  two's-complement overflow of the full-width add.
- add_a, add_b  out  32  adder operand drive; registered.
- add_c  out  1  adder carry-in drive; registered.
- add_sum  in  32  adder sum output.
- add_cout  in  1  adder carry output.

## Operation
- States: IDLE, FEED, CAPT.
- IDLE + start:
  - Latch a_wide, b_wide and cin.
  - Set idx=0.
  - Register add_a=A[31:0], add_b=B[31:0], add_c=cin.
  - Go to FEED.
- IDLE without start: stay in IDLE. start while busy is ignored; there is no queueing.
- FEED → CAPT unconditionally. The adder registers the limb on this edge.
- CAPT:
  - Write add_sum into result[32·idx +: 32].
  - If idx < WORDS-1: register limb idx+1 on add_a/add_b, set add_c=add_cout, increment idx, go to FEED.
  - If idx = WORDS-1: set cout=add_cout, set ovf=(A_msb==B_msb)&&(add_sum[31]!=A_msb), pulse done, go to IDLE.
- result is updated limb by limb during a request. It is only valid while done is high, and stays valid afterwards until the next start.
- Width rule: all arithmetic is modulo 2^(32·WORDS). cout is the only carry beyond the MS limb.
- Reset values (clk edge with rst_n=0):
  - state=IDLE, idx=0.
  - add_a=0, add_b=0, add_c=0.
  - result=0, cout=0, ovf=0, done=0, busy=0.
  - Operand latches cleared.
- Reset mid-operation aborts the request with no done pulse. The adder clears on the same edge, so no stale limb survives.
- start in the same cycle that done is high is accepted, because the state is already IDLE.

## Timing
- Throughput is one limb per 2 cycles, because each limb's carry depends on the previous limb's result.
- start sampled at edge E0:
  - limb k is presented to the adder after E(2k);
  - limb k's sum is captured at E(2k+2);
  - done is high for the cycle after E(2·WORDS).
  - For WORDS=4, done is high 8 cycles after start is sampled.
- busy is high from the cycle after E0 through the cycle after E(2·WORDS−1). It is low in the done cycle.
- The adder port outputs are registered, so there is no combinational path from add_sum/add_cout to add_a/add_b/add_c.

## Structure
- Package mp_add_pkg:
  - WORD_W=32;
  - state enum {IDLE, FEED, CAPT};
  - idx width given by $clog2(WORDS).
- No sub-module. The integration top instantiates mp_add_seq and adder32 side by side on the same clk/rst_n.
- The bench uses adder32 as the adder model.

## Test plan
All scenarios use WORDS=4.
- A=2^128−1, B=1, cin=0 → result=0, cout=1, ovf=0. add_c is 1 on limbs 1–3. done is high exactly 8 cycles after start.
- A=0x7FFF…FFFF, B=1, cin=0 → result=0x8000_0000_…_0000, cout=0, ovf=1.
- A=0, B=0, cin=1 → result=1, cout=0, ovf=0. add_c is 1 only on limb 0.
- Assert start again at cycles 2–5 of a request → those starts are ignored and exactly one done occurs. Then assert start in the done cycle → it is accepted, and busy rises on the next cycle.
- Drop rst_n at cycle 3 of a request → all outputs are 0 and no done occurs. The next start with A=5, B=7 gives result=12.
- Change a_wide/b_wide every cycle after start → result reflects the operands latched at the start edge.
